jstk2_servo_pwm: RTL and testbench

Converts joystick packets from the Pmod JSTK2 SPI stage into a standard RC-servo PWM signal. It sits directly downstream of the SPI controller and takes the 40-bit packet plus a one-cycle valid strobe. It extracts the 10-bit X position, maps it linearly to a 1–2 ms pulse, and emits one pulse per 20 ms frame. A link watchdog silences the output when packets stop arriving.

---
 rtl/jstk2_pkg.sv | 25 ++
 rtl/servo_pulse_gen.sv | 49 ++++
 rtl/jstk2_servo_pwm.sv | 146 ++++++++++++++
 tb/tb_jstk2_servo_pwm.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/jstk2_pkg.sv
// Shared definitions for the JSTK2 joystick-to-servo PWM block.
// Packet field offsets, FSM states and the microsecond-to-tick helper.
package jstk2_pkg;

  localparam int PKT_W    = 40;
  localparam int X_W      = 10;
  localparam int X_LO_LSB = 32;
  localparam int X_HI_LSB = 24;
  localparam int Y_LO_LSB = 16;
  localparam int Y_HI_LSB = 8;
  localparam int BTN_LSB  = 0;

  typedef enum logic {
    WAIT_DATA,
    FRAME
  } state_e;

  function automatic int us_to_ticks(
    input longint clk_hz,
    input longint us
  );
    return int'((clk_hz / longint'(1_000_000)) * us);
  endfunction

endpackage

// File: rtl/servo_pulse_gen.sv
// Frame counter and pulse comparator for the servo PWM.
// Width is sampled only at count 0 so a frame is never altered mid-pulse.
module servo_pulse_gen #(
  parameter int PERIOD_TICKS = 2_000_000,
  parameter int CW           = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_i,
  input  logic [CW-1:0] width_i,
  output logic          pwm_o,
  output logic          frame_wrap_o
);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] width_q, width_d;
  logic [CW-1:0] cur_width;
  logic          start;
  logic          last;

  assign start = enable_i && (count_q == '0);
  assign last  = (count_q == CW'(PERIOD_TICKS - 1));

  // The first cycle of a frame compares against the incoming width.
  assign cur_width = start ? width_i : width_q;

  always_comb begin
    count_d = '0;
    width_d = width_q;
    if (enable_i) begin
      count_d = last ? '0 : count_q + CW'(1);
      if (start) width_d = width_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      width_q <= '0;
    end else begin
      count_q <= count_d;
      width_q <= width_d;
    end
  end

  assign frame_wrap_o = enable_i && last;
  assign pwm_o        = enable_i && (count_q < cur_width);

endmodule

// File: rtl/jstk2_servo_pwm.sv
// JSTK2 X position to RC-servo PWM with link watchdog.
// Define JSTK2_DEADZONE_EN to snap X near centre to 512.
module jstk2_servo_pwm
  import jstk2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int PERIOD_US      = 20_000,
  parameter int MIN_PULSE_US   = 1_000,
  parameter int MAX_PULSE_US   = 2_000,
  parameter int TIMEOUT_FRAMES = 50,
  parameter int DEADZONE       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             xy_valid,
  input  logic [PKT_W-1:0] xy_values,
  output logic             pwm_out,
  output logic             active,
  output logic [X_W-1:0]   x_pos
);

  localparam int MIN_TICKS =
    us_to_ticks(CLK_FREQ_HZ, MIN_PULSE_US);
  localparam int SPAN_TICKS =
    us_to_ticks(CLK_FREQ_HZ, MAX_PULSE_US - MIN_PULSE_US);
  localparam int PERIOD_TICKS =
    us_to_ticks(CLK_FREQ_HZ, PERIOD_US);

  localparam int CW = $clog2(PERIOD_TICKS + 1);
  localparam int SW = $clog2(SPAN_TICKS + 1);
  localparam int PW = X_W + SW;
  localparam int MW = $clog2(TIMEOUT_FRAMES + 1);

  logic [X_W-1:0] x_q, x_d, x_eff;
  logic [PW-1:0]  prod_q, prod_d;
  logic [CW-1:0]  pend_q, pend_d;
  logic           v1_q, v2_q, v3_q;

  state_e         state_q;
  logic           active_q;
  logic [MW-1:0]  miss_q;

  logic           pwm;
  logic           wrap;
  logic           unused_bits;

  assign unused_bits = ^{
    xy_values[31:26],
    xy_values[Y_LO_LSB +: 8],
    xy_values[15:10],
    xy_values[Y_HI_LSB +: 2],
    xy_values[BTN_LSB +: 8]
  };

  assign x_d = {
    xy_values[X_HI_LSB +: 2],
    xy_values[X_LO_LSB +: 8]
  };

`ifdef JSTK2_DEADZONE_EN
  localparam logic [X_W-1:0] DZ_LO = X_W'(512 - DEADZONE);
  localparam logic [X_W-1:0] DZ_HI = X_W'(512 + DEADZONE);

  assign x_eff = (x_q >= DZ_LO && x_q <= DZ_HI)
               ? X_W'(512) : x_q;
`else
  localparam int UNUSED_DZ = DEADZONE;

  assign x_eff = x_q;
`endif

  assign prod_d = PW'(x_eff) * PW'(SPAN_TICKS);
  assign pend_d = CW'(MIN_TICKS) + CW'(prod_q >> 10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      prod_q <= '0;
      pend_q <= CW'(MIN_TICKS);
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
    end else begin
      v1_q <= xy_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (xy_valid) x_q    <= x_d;
      if (v1_q)     prod_q <= prod_d;
      if (v2_q)     pend_q <= pend_d;
    end
  end

  // A strobe on the wrap cycle has priority over the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_DATA;
      active_q <= 1'b0;
      miss_q   <= '0;
    end else begin
      unique case (state_q)
        WAIT_DATA: begin
          miss_q <= '0;
          if (v3_q) begin
            state_q  <= FRAME;
            active_q <= 1'b1;
          end
        end
        FRAME: begin
          if (xy_valid) begin
            miss_q <= '0;
          end else if (wrap) begin
            if (miss_q == MW'(TIMEOUT_FRAMES - 1)) begin
              state_q  <= WAIT_DATA;
              active_q <= 1'b0;
              miss_q   <= '0;
            end else begin
              miss_q <= miss_q + MW'(1);
            end
          end
        end
        default: begin
          state_q  <= WAIT_DATA;
          active_q <= 1'b0;
          miss_q   <= '0;
        end
      endcase
    end
  end

  servo_pulse_gen #(
    .PERIOD_TICKS (PERIOD_TICKS),
    .CW           (CW)
  ) u_gen (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (state_q == FRAME),
    .width_i      (pend_q),
    .pwm_o        (pwm),
    .frame_wrap_o (wrap)
  );

  assign pwm_out = pwm;
  assign active  = active_q;
  assign x_pos   = x_q;

endmodule

// File: tb/tb_jstk2_servo_pwm.sv
// Randomized scoreboard bench for jstk2_servo_pwm.
// Reduced timing parameters keep frames short.
module tb_jstk2_servo_pwm;

  localparam int CLK_HZ = 1_000_000;
  localparam int PER_US = 600;
  localparam int MIN_US = 100;
  localparam int MAX_US = 357;
  localparam int TO     = 4;
  localparam int DZ     = 16;

  localparam int TPU    = CLK_HZ / 1_000_000;
  localparam int P      = TPU * PER_US;
  localparam int MIN_T  = TPU * MIN_US;
  localparam int SPAN_T = TPU * (MAX_US - MIN_US);

  typedef struct {
    longint rdy;
    int     w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        xy_valid = 1'b0;
  logic [39:0] xy_values = '0;
  logic        pwm_out;
  logic        active;
  logic [9:0]  x_pos;

  longint cyc = 0;
  int     tests = 0;
  int     fails = 0;
  exp_t   sb[$];
  int     rises_cnt = 0;
  longint last_rise = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jstk2_servo_pwm #(
    .CLK_FREQ_HZ    (CLK_HZ),
    .PERIOD_US      (PER_US),
    .MIN_PULSE_US   (MIN_US),
    .MAX_PULSE_US   (MAX_US),
    .TIMEOUT_FRAMES (TO),
    .DEADZONE       (DZ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .xy_valid  (xy_valid),
    .xy_values (xy_values),
    .pwm_out   (pwm_out),
    .active    (active),
    .x_pos     (x_pos)
  );

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_width(input int x);
    int xe;
    xe = x;
`ifdef JSTK2_DEADZONE_EN
    if (x >= 512 - DZ && x <= 512 + DZ) xe = 512;
`endif
    return MIN_T + (xe * SPAN_T) / 1024;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input longint t);
    while (cyc < t) step(1);
  endtask

  task automatic send(input int x);
    exp_t e;
    xy_values = {x[7:0], 6'($urandom), x[9:8], 24'($urandom)};
    xy_valid  = 1'b1;
    e.rdy = cyc + 3;
    e.w   = exp_width(x);
    sb.push_back(e);
    step(1);
    xy_valid = 1'b0;
    chk("x_pos", longint'(x_pos), longint'(x));
  endtask

  task automatic wait_pwm_high(input int budget);
    int n;
    n = 0;
    while (!pwm_out && n < budget) begin
      step(1);
      n++;
    end
    chk("pwm_high_seen", longint'(pwm_out), 1);
  endtask

  task automatic wait_idle(input int budget, output longint when);
    int n;
    n = 0;
    while (active && n < budget) begin
      step(1);
      n++;
    end
    when = cyc;
    chk("went_idle", longint'(active), 0);
  endtask

  // Scoreboard monitor: measures every pulse and frame start.
  initial begin
    bit     pp, pa, inp;
    int     cur_w;
    pp = 0; pa = 0; inp = 0; cur_w = MIN_T;
    forever begin
      @(negedge clk);
      if (rst) begin
        pp = 0; pa = 0; inp = 0;
      end else begin
        if (pwm_out && !pp) begin
          if (!pa) begin
            if (sb.size() == 0)
              chk("spurious_rise", cyc, -1);
            else
              chk("first_rise_lat", cyc, sb[0].rdy + 1);
          end else begin
            chk("period", cyc - last_rise, P);
          end
          while (sb.size() > 0 && sb[0].rdy <= cyc)
            cur_w = sb.pop_front().w;
          last_rise = cyc;
          rises_cnt++;
          inp = 1;
        end
        if (!pwm_out && pp && inp) begin
          chk("pulse_width", cyc - last_rise, cur_w);
          inp = 0;
        end
        pp = pwm_out;
        pa = active;
      end
    end
  end

  initial begin
    #(60_000 * 10);
    $display("FAIL global_timeout: got %0d cycles expected <60000",
             cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int     dir[4];
    longint f0, t_idle;
    int     r0, r;

    step(3);
    chk("rst_pwm", longint'(pwm_out), 0);
    chk("rst_active", longint'(active), 0);
    chk("rst_xpos", longint'(x_pos), 0);
    rst = 1'b0;
    step(5);
    chk("idle_no_pkt", longint'(active), 0);

    send(512);
    step(2 * P);
    wait_pwm_high(P);
    step(3);
    send(0);
    step(2 * P);
    send(1023);
    step(2 * P);

    dir = '{495, 496, 528, 529};
    for (int i = 0; i < 12; i++) begin
      int x;
      x = (i < 4) ? dir[i] : int'($urandom_range(0, 1023));
      send(x);
      if ($urandom_range(0, 3) != 0)
        step(int'($urandom_range(1, P - 1)));
    end
    step(P);

    r = rises_cnt;
    for (int n = 0; n < 2 * P && rises_cnt == r; n++) step(1);
    wait_until(last_rise + P - 1);
    send(int'($urandom_range(0, 1023)));

    r0 = rises_cnt;
    wait_idle((TO + 2) * P, t_idle);
    chk("timeout_frames", rises_cnt - r0, TO);
    chk("timeout_pwm", longint'(pwm_out), 0);
    step(P);
    chk("stay_idle", longint'(active), 0);

    r0 = rises_cnt;
    f0 = cyc + 4;
    send(int'($urandom_range(0, 1023)));
    wait_until(f0 + TO * P - 1);
    send(int'($urandom_range(0, 1023)));
    step(1);
    chk("rescued_active", longint'(active), 1);
    wait_idle((TO + 2) * P, t_idle);
    chk("idle_cycle", t_idle, f0 + 2 * TO * P);
    chk("rescued_frames", rises_cnt - r0, 2 * TO);

    send(int'($urandom_range(0, 1023)));
    wait_pwm_high(10);
    step(5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pwm", longint'(pwm_out), 0);
    chk("arst_active", longint'(active), 0);
    chk("arst_xpos", longint'(x_pos), 0);
    sb.delete();
    step(2);
    rst = 1'b0;
    step(2 * P);
    chk("post_rst_pwm", longint'(pwm_out), 0);
    chk("post_rst_active", longint'(active), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
